// File: rtl/pcu_sequencer.sv
// Control sequencer for the program control unit: fetch, PC increment, GOTO
// operand fetch/jump, and the execute handshake toward the ALU controller.
module pcu_sequencer #(
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [1:0] GOTO_OPC    = 2'b11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       halt_req,
  input  logic [7:0] inst,
  input  logic       cond_taken,
  input  logic       mem_ack,
  input  logic       exec_done,
  output logic       mem_rd,
  output logic       sel_pc,
  output logic       sel_inc,
  output logic       sel_j,
  output logic       ld_inst,
  output logic       ld_inc,
  output logic       ld_pc,
  output logic       ld_j1,
  output logic       ld_j2,
  output logic       exec_req,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_INC_F,
    S_PCUPD_F,
    S_DECODE,
    S_EXEC,
    S_J1_RD,
    S_INC_J1,
    S_PCUPD_J1,
    S_J2_RD,
    S_INC_J2,
    S_PCUPD_J2,
    S_JUMP,
    S_BOUNDARY,
    S_HALT
  } state_t;

  localparam int             CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST_WAIT = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          in_rd;
  logic          timeout;
  logic          bus_err_q;
  logic          unused_inst_bits;

  // Only the opcode field matters here; the low bits belong to the execute side.
  assign unused_inst_bits = ^inst[5:0];

  assign in_rd   = (state == S_FETCH) || (state == S_J1_RD) || (state == S_J2_RD);
  // An ack in the final allowed wait cycle still wins over the timeout.
  assign timeout = in_rd && !mem_ack && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every read state is entered from a non-read state, so the count is zero on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!in_rd) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err_q <= 1'b0;
    end else if (timeout) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (run) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      next_state = S_INC_F;
        else if (timeout) next_state = S_HALT;
      end
      S_INC_F:    next_state = S_PCUPD_F;
      S_PCUPD_F:  next_state = S_DECODE;
      S_DECODE:   next_state = (inst[7:6] == GOTO_OPC) ? S_J1_RD : S_EXEC;
      S_EXEC:     if (exec_done) next_state = S_BOUNDARY;
      S_J1_RD: begin
        if (mem_ack)      next_state = S_INC_J1;
        else if (timeout) next_state = S_HALT;
      end
      S_INC_J1:   next_state = S_PCUPD_J1;
      S_PCUPD_J1: next_state = S_J2_RD;
      S_J2_RD: begin
        if (mem_ack)      next_state = S_INC_J2;
        else if (timeout) next_state = S_HALT;
      end
      S_INC_J2:   next_state = S_PCUPD_J2;
      S_PCUPD_J2: next_state = S_JUMP;
      S_JUMP:     next_state = S_BOUNDARY;
      S_BOUNDARY: next_state = (halt_req || !run) ? S_HALT : S_FETCH;
      S_HALT:     if (run && !halt_req) next_state = S_FETCH;
      default:    next_state = S_IDLE;
    endcase
  end

  // Strobes decode the state register; only the load strobes qualify on ack/cond.
  always_comb begin
    mem_rd   = 1'b0;
    sel_pc   = 1'b0;
    sel_inc  = 1'b0;
    sel_j    = 1'b0;
    ld_inst  = 1'b0;
    ld_inc   = 1'b0;
    ld_pc    = 1'b0;
    ld_j1    = 1'b0;
    ld_j2    = 1'b0;
    exec_req = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        sel_pc  = 1'b1;
        ld_inst = mem_ack;
      end
      S_J1_RD: begin
        mem_rd = 1'b1;
        sel_pc = 1'b1;
        ld_j1  = mem_ack;
      end
      S_J2_RD: begin
        mem_rd = 1'b1;
        sel_pc = 1'b1;
        ld_j2  = mem_ack;
      end
      S_INC_F, S_INC_J1, S_INC_J2: begin
        sel_pc = 1'b1;
        ld_inc = 1'b1;
      end
      S_PCUPD_F, S_PCUPD_J1, S_PCUPD_J2: begin
        sel_inc = 1'b1;
        ld_pc   = 1'b1;
      end
      S_EXEC:  exec_req = 1'b1;
      S_JUMP: begin
        sel_j = 1'b1;
        ld_pc = cond_taken;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
